// File: rtl/edge_pipe_seq_if.sv
// Control/kernel bundle for the edge-detector frame sequencer.
// Optional macro PERF_CNT_EN adds the CNT_BITS parameter and the cyc_cnt signal.
// Signals: start/abort in, busy/done out, per-stage stg_rst_n/stg_run out,
//   stg_done in, cur_stg and src/dst/res_buf_sel out, cyc_cnt out (perf only).
// master = sequencer side, slave = controller/kernel side.
interface edge_pipe_seq_if #(
    parameter int NUM_STG  = 4,
    parameter int STG_BITS = 2
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_BITS = 32
`endif
);
    logic                start;
    logic                abort;
    logic                busy;
    logic                done;
    logic [NUM_STG-1:0]  stg_rst_n;
    logic [NUM_STG-1:0]  stg_run;
    logic [NUM_STG-1:0]  stg_done;
    logic [STG_BITS-1:0] cur_stg;
    logic                src_buf_sel;
    logic                dst_buf_sel;
    logic                res_buf_sel;
`ifdef PERF_CNT_EN
    logic [CNT_BITS-1:0] cyc_cnt;
`endif

    modport master (
        input  start, abort, stg_done,
        output busy, done, stg_rst_n, stg_run, cur_stg,
        output src_buf_sel, dst_buf_sel, res_buf_sel
`ifdef PERF_CNT_EN
        ,
        output cyc_cnt
`endif
    );

    modport slave (
        output start, abort, stg_done,
        input  busy, done, stg_rst_n, stg_run, cur_stg,
        input  src_buf_sel, dst_buf_sel, res_buf_sel
`ifdef PERF_CNT_EN
        ,
        input  cyc_cnt
`endif
    );
endinterface

// File: rtl/edge_pipe_seq.sv
// Frame-level sequencer: runs NUM_STG kernels in order, clear then run each,
// ping-ponging frame buffers. Optional macro PERF_CNT_EN adds cyc_cnt.
// Ports: clk, rst_n (sync, active low), ctl (edge_pipe_seq_if.master):
//   start/abort/stg_done in; busy/done/stg_rst_n/stg_run/cur_stg,
//   src/dst/res_buf_sel and (perf) cyc_cnt out.
module edge_pipe_seq #(
    parameter int NUM_STG  = 4,
    parameter int STG_BITS = 2
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_BITS = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    edge_pipe_seq_if.master  ctl
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_FIN
    } state_t;

    localparam logic [STG_BITS-1:0] LAST = STG_BITS'(NUM_STG - 1);

    state_t              r_state;
    logic [STG_BITS-1:0] r_stg;
    logic                r_busy;
    logic                r_done;
    logic [NUM_STG-1:0]  r_run;
    logic [NUM_STG-1:0]  r_rst_n;

    logic [STG_BITS-1:0] w_nxt_stg;
    logic [NUM_STG-1:0]  w_oh;
    logic [NUM_STG-1:0]  w_nxt_oh;
    logic                w_go;
    logic                w_stg_end;
    logic                w_fin_go;

    assign w_nxt_stg = r_stg + STG_BITS'(1);
    assign w_oh      = NUM_STG'(1) << r_stg;
    assign w_nxt_oh  = NUM_STG'(1) << w_nxt_stg;
    assign w_go      = (r_state == S_IDLE) && ctl.start && !ctl.abort;
    // r_run is one-hot on the active stage, so this masks out idle stages
    assign w_stg_end = (r_state == S_RUN) && !ctl.abort
                       && |(ctl.stg_done & r_run);
    assign w_fin_go  = w_stg_end && (r_stg == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_stg   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_run   <= '0;
            r_rst_n <= '1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state <= S_CLR;
                        r_stg   <= '0;
                        r_busy  <= 1'b1;
                        r_rst_n <= ~(NUM_STG'(1));
                    end
                end
                S_CLR: begin
                    r_rst_n <= '1;
                    if (ctl.abort) begin
                        r_state <= S_IDLE;
                        r_stg   <= '0;
                        r_busy  <= 1'b0;
                        r_run   <= '0;
                    end else begin
                        r_state <= S_RUN;
                        r_run   <= w_oh;
                    end
                end
                S_RUN: begin
                    if (ctl.abort) begin
                        r_state <= S_IDLE;
                        r_stg   <= '0;
                        r_busy  <= 1'b0;
                        r_run   <= '0;
                    end else if (w_stg_end) begin
                        r_run <= '0;
                        if (w_fin_go) begin
                            r_state <= S_FIN;
                            r_stg   <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_CLR;
                            r_stg   <= w_nxt_stg;
                            r_rst_n <= ~w_nxt_oh;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ctl.busy        = r_busy;
    assign ctl.done        = r_done;
    assign ctl.stg_run     = r_run;
    assign ctl.stg_rst_n   = r_rst_n;
    assign ctl.cur_stg     = r_stg;
    assign ctl.src_buf_sel = r_stg[0];
    assign ctl.dst_buf_sel = ~r_stg[0];
    assign ctl.res_buf_sel = (NUM_STG % 2) == 1;

`ifdef PERF_CNT_EN
    logic [CNT_BITS-1:0] r_cnt;
    logic [CNT_BITS-1:0] r_cyc;
    logic [CNT_BITS-1:0] w_cnt_nxt;

    // saturating increment; also the value latched on the final busy edge
    assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_BITS'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_cyc <= '0;
        end else begin
            if (w_go) begin
                r_cnt <= '0;
            end else if (r_busy) begin
                r_cnt <= w_cnt_nxt;
            end
            if (w_fin_go) begin
                r_cyc <= w_cnt_nxt;
            end
        end
    end

    assign ctl.cyc_cnt = r_cyc;
`endif
endmodule

// File: tb/tb_edge_pipe_seq.sv
// Directed bench for edge_pipe_seq: stub kernels with programmable run lengths,
// table of full-pass vectors plus abort, start-while-busy and reset sequences.
module tb_edge_pipe_seq;
    localparam int NS = 4;
    localparam int SB = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    edge_pipe_seq_if #(.NUM_STG(NS), .STG_BITS(SB)) ctl();

    edge_pipe_seq #(.NUM_STG(NS), .STG_BITS(SB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (ctl.master)
    );

    // stub kernels: done on the klen-th run cycle after a clear
    int kcnt [NS];
    int klen [NS];
    logic [NS-1:0] force_done = '0;
    logic [NS-1:0] w_done;

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!ctl.stg_rst_n[i]) kcnt[i] <= 0;
            else if (ctl.stg_run[i]) kcnt[i] <= kcnt[i] + 1;
        end
    end

    always_comb begin
        w_done = '0;
        for (int i = 0; i < NS; i++)
            w_done[i] = force_done[i] |
                        (ctl.stg_run[i] && (kcnt[i] == klen[i] - 1));
    end
    assign ctl.stg_done = w_done;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // pass statistics
    int n_busy, first_busy, last_busy, n_done, done_cyc, n_viol;
    int run_len [NS];
    logic sn_busy, sn_done;
    logic [NS-1:0] sn_run, sn_rstn;
    logic [SB-1:0] sn_stg;

    task automatic do_pass(input int ncyc, input int abort_at,
                           input int s1, input int s2,
                           input int rst_at, input int snap_at);
        logic [NS-1:0] prev_rstn;
        logic [NS-1:0] prev_run;
        n_busy = 0; first_busy = 0; last_busy = 0;
        n_done = 0; done_cyc = 0; n_viol = 0;
        for (int i = 0; i < NS; i++) run_len[i] = 0;
        prev_rstn = '1;
        prev_run = '0;
        @(negedge clk);
        ctl.start = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (ctl.busy) begin
                n_busy++;
                if (first_busy == 0) first_busy = c;
                last_busy = c;
            end
            if (ctl.done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = c;
                if (ctl.busy || ctl.cur_stg != 0) n_viol++;
            end
            if ($countones(ctl.stg_run) > 1) n_viol++;
            if ($countones(~ctl.stg_rst_n) > 1) n_viol++;
            if (ctl.stg_rst_n != '1 && ctl.stg_run != '0) n_viol++;
            for (int i = 0; i < NS; i++) begin
                if (ctl.stg_run[i]) begin
                    run_len[i]++;
                    if (ctl.cur_stg != SB'(i)) n_viol++;
                    if (ctl.src_buf_sel != ((i % 2) == 1)) n_viol++;
                    if (ctl.dst_buf_sel != ((i % 2) == 0)) n_viol++;
                    if (!prev_run[i] && prev_rstn[i]) n_viol++;
                end
                if (!prev_rstn[i] && !ctl.stg_run[i]
                    && c - 1 != abort_at && c - 1 != rst_at) n_viol++;
            end
            if (c == snap_at) begin
                sn_busy = ctl.busy; sn_done = ctl.done;
                sn_run = ctl.stg_run; sn_rstn = ctl.stg_rst_n;
                sn_stg = ctl.cur_stg;
            end
            prev_rstn = ctl.stg_rst_n;
            prev_run = ctl.stg_run;
            ctl.start = (c == s1) || (c == s2);
            ctl.abort = (c == abort_at);
            rst_n = !(c == rst_at);
        end
        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int l0, l1, l2, l3;
        int busy;
        int done_at;
    } vec_t;

    vec_t vt [4];
    int idle_busy;

    initial begin
        vt[0] = '{16, 16, 16, 16, 68, 69};
        vt[1] = '{16, 16,  1, 16, 53, 54};
        vt[2] = '{ 1,  1,  1,  1,  8,  9};
        vt[3] = '{ 3,  5,  2,  7, 21, 22};

        ctl.start = 1'b0;
        ctl.abort = 1'b0;
        for (int i = 0; i < NS; i++) klen[i] = 16;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", ctl.busy, 0);
        chk("rst_done", ctl.done, 0);
        chk("rst_run", ctl.stg_run, 0);
        chk("rst_rstn", ctl.stg_rst_n, 4'hF);
        chk("rst_stg", ctl.cur_stg, 0);
        chk("res_buf", ctl.res_buf_sel, 0);
`ifdef PERF_CNT_EN
        chk("rst_cyc", ctl.cyc_cnt, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // full passes
        for (int v = 0; v < 4; v++) begin
            klen[0] = vt[v].l0; klen[1] = vt[v].l1;
            klen[2] = vt[v].l2; klen[3] = vt[v].l3;
            do_pass(vt[v].done_at + 3, 0, 0, 0, 0, 0);
            chk($sformatf("v%0d_first_busy", v), first_busy, 1);
            chk($sformatf("v%0d_last_busy", v), last_busy, vt[v].busy);
            chk($sformatf("v%0d_n_busy", v), n_busy, vt[v].busy);
            chk($sformatf("v%0d_n_done", v), n_done, 1);
            chk($sformatf("v%0d_done_cyc", v), done_cyc, vt[v].done_at);
            chk($sformatf("v%0d_run0", v), run_len[0], vt[v].l0);
            chk($sformatf("v%0d_run2", v), run_len[2], vt[v].l2);
            chk($sformatf("v%0d_viol", v), n_viol, 0);
`ifdef PERF_CNT_EN
            chk($sformatf("v%0d_cyc", v), ctl.cyc_cnt, vt[v].busy);
`endif
        end

        // abort on the 5th RUN cycle of stage 1 (cycle 23)
        for (int i = 0; i < NS; i++) klen[i] = 16;
        do_pass(40, 23, 0, 0, 0, 24);
        chk("ab_n_done", n_done, 0);
        chk("ab_n_busy", n_busy, 23);
        chk("ab_run1", run_len[1], 5);
        chk("ab_busy", sn_busy, 0);
        chk("ab_run", sn_run, 0);
        chk("ab_stg", sn_stg, 0);
        chk("ab_viol", n_viol, 0);
`ifdef PERF_CNT_EN
        chk("ab_cyc", ctl.cyc_cnt, 21);
`endif
        do_pass(72, 0, 0, 0, 0, 0);
        chk("ab_re_busy", n_busy, 68);
        chk("ab_re_done", done_cyc, 69);
        chk("ab_re_viol", n_viol, 0);

        // start pulses while busy are ignored
        do_pass(75, 0, 10, 40, 0, 0);
        chk("st_n_done", n_done, 1);
        chk("st_n_busy", n_busy, 68);
        chk("st_done_cyc", done_cyc, 69);

        // abort + start together in IDLE
        ctl.start = 1'b1;
        ctl.abort = 1'b1;
        idle_busy = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ctl.start = 1'b0;
            ctl.abort = 1'b0;
            if (ctl.busy || ctl.stg_rst_n != '1 || ctl.done) idle_busy++;
        end
        chk("as_idle", idle_busy, 0);

        // reset during stage 3 RUN (cycle 60)
        do_pass(66, 0, 0, 0, 60, 61);
        chk("rs_n_done", n_done, 0);
        chk("rs_busy", sn_busy, 0);
        chk("rs_done", sn_done, 0);
        chk("rs_run", sn_run, 0);
        chk("rs_rstn", sn_rstn, 4'hF);
        chk("rs_stg", sn_stg, 0);
        chk("rs_run3", run_len[3], 8);
`ifdef PERF_CNT_EN
        chk("rs_cyc", ctl.cyc_cnt, 0);
`endif

        // spurious stg_done[3] in IDLE
        force_done = 4'b1000;
        idle_busy = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ctl.busy || ctl.stg_run != '0 || ctl.done) idle_busy++;
        end
        force_done = '0;
        chk("sp_idle", idle_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
